// File: rtl/mem_copy_pkg.sv
// Shared widths and FSM state encoding for the memory copy engine.
// Optional fill mode in mem_copy_engine is enabled with macro MEM_COPY_FILL_EN.
package mem_copy_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_copy_engine.sv
// Memory copy engine: copies len bytes from srcAddr to dstAddr one byte at a
// time, in ascending order, through a single-port memory with registered read
// data. Addresses wrap modulo 32. Overlapping regions are copied naively, so a
// later read sees bytes already written by the same transfer.
//
// Build option: define MEM_COPY_FILL_EN to add the fill/fillValue inputs. With
// fill=1 on start the READ phase is skipped and every destination byte is
// written with the latched fillValue.
//
// Handshake: start is a level sampled only in IDLE; it is a request, not a
// valid/ready pair, so starts seen in READ, WRITE or DONE are dropped without
// queueing. done is a single-cycle completion pulse. dbg_state mirrors the FSM
// state register for observation.
module mem_copy_engine
  import mem_copy_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] srcAddr,
  input  logic [ADDR_W-1:0] dstAddr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] writeData,
  output logic              memRead,
  output logic              memWrite,
  input  logic [DATA_W-1:0] memOut,
`ifdef MEM_COPY_FILL_EN
  input  logic              fill,
  input  logic [DATA_W-1:0] fillValue,
`endif
  output logic [1:0]        dbg_state
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  cnt_inc;
  logic              last_byte;

  // Fill mode plumbing; tied off when the option is not built.
  logic              fill_start;
  logic              fill_mode;
  logic [DATA_W-1:0] fill_data;

`ifdef MEM_COPY_FILL_EN
  logic              fill_q, fill_d;
  logic [DATA_W-1:0] fill_value_q, fill_value_d;

  // Fill options are captured together with the transfer operands.
  always_comb begin
    fill_d       = fill_q;
    fill_value_d = fill_value_q;
    if (state_q == ST_IDLE && start) begin
      fill_d       = fill;
      fill_value_d = fillValue;
    end
  end

  // Fill option registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fill_q       <= 1'b0;
      fill_value_q <= '0;
    end else begin
      fill_q       <= fill_d;
      fill_value_q <= fill_value_d;
    end
  end

  assign fill_start = fill;
  assign fill_mode  = fill_q;
  assign fill_data  = fill_value_q;
`else
  assign fill_start = 1'b0;
  assign fill_mode  = 1'b0;
  assign fill_data  = '0;
`endif

  // Byte counter after the current write; the transfer ends when it hits len.
  always_comb begin
    cnt_inc   = cnt_q + LEN_W'(1);
    last_byte = (cnt_inc == len_q);
  end

  // Next-state, operand update and memory strobe decode.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    busy      = 1'b0;
    done      = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    address   = '0;
    writeData = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_d = srcAddr;
          dst_d = dstAddr;
          len_d = len;
          cnt_d = '0;
          if (len == '0) begin
            state_d = ST_DONE;
          end else if (fill_start) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end

      ST_READ: begin
        busy    = 1'b1;
        memRead = 1'b1;
        address = src_q;
        state_d = ST_WRITE;
      end

      ST_WRITE: begin
        busy      = 1'b1;
        memWrite  = 1'b1;
        address   = dst_q;
        writeData = fill_mode ? fill_data : memOut;
        // 5-bit address registers wrap 31 -> 0 naturally.
        src_d     = src_q + ADDR_W'(1);
        dst_d     = dst_q + ADDR_W'(1);
        cnt_d     = cnt_inc;
        if (last_byte) begin
          state_d = ST_DONE;
        end else if (fill_mode) begin
          state_d = ST_WRITE;
        end else begin
          state_d = ST_READ;
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and operand registers; reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: table of copy transfers checked cycle by cycle
// against a byte-level model of the memory, plus hand-written reset cases.
// Fill-mode vector runs only when MEM_COPY_FILL_EN is defined.
module tb_mem_copy_engine;
  import mem_copy_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] srcAddr = '0;
  logic [ADDR_W-1:0] dstAddr = '0;
  logic [LEN_W-1:0]  len = '0;
  logic              busy, done, memRead, memWrite;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writeData;
  logic [DATA_W-1:0] memOut = '0;
  logic [1:0]        dbg_state;
`ifdef MEM_COPY_FILL_EN
  logic              fill = 1'b0;
  logic [DATA_W-1:0] fillValue = '0;
`endif

  // Memory contents and the bench's own expectation of them.
  logic [DATA_W-1:0] mem [32];
  logic [DATA_W-1:0] mdl [32];
  logic              pre_we = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [DATA_W-1:0] pre_data = '0;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [ADDR_W-1:0] s;
    logic [ADDR_W-1:0] d;
    logic [LEN_W-1:0]  n;
    int                lat;
    int                pulse_at;
  } vec_t;

  vec_t vecs [7];

  // Clock.
  always #5 clk = ~clk;

  mem_copy_engine dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .srcAddr   (srcAddr),
    .dstAddr   (dstAddr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .address   (address),
    .writeData (writeData),
    .memRead   (memRead),
    .memWrite  (memWrite),
    .memOut    (memOut),
`ifdef MEM_COPY_FILL_EN
    .fill      (fill),
    .fillValue (fillValue),
`endif
    .dbg_state (dbg_state)
  );

  // Memory block: registered read data; shares the system reset, so strobes
  // are ignored while rst is low. Bench preload port has priority.
  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (rst) begin
      if (memRead) memOut <= mem[address];
      if (memWrite) mem[address] <= writeData;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = v;
    @(negedge clk);
    pre_we = 1'b0;
    mdl[a] = v;
  endtask

  task automatic check_mem(input string name);
    int diff;
    diff = 0;
    for (int j = 0; j < 32; j++) if (mem[j] !== mdl[j]) diff++;
    check(name, diff, 0);
  endtask

  // Runs one transfer and checks every cycle against the expected sequence.
  task automatic run_copy(input string name, input logic [ADDR_W-1:0] s,
                          input logic [ADDR_W-1:0] d, input logic [LEN_W-1:0] n,
                          input logic f, input logic [DATA_W-1:0] fv,
                          input int exp_lat, input int pulse_at);
    int lat, seq_bad, i;
    logic [ADDR_W-1:0] ra, wa;
    logic [DATA_W-1:0] exp_wd;
    lat = -1; seq_bad = 0;
    @(negedge clk);
    srcAddr = s; dstAddr = d; len = n; start = 1'b1;
`ifdef MEM_COPY_FILL_EN
    fill = f; fillValue = fv;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        if (busy || memRead || memWrite || address != '0 || writeData != '0) seq_bad++;
      end else begin
        if (!busy || (memRead && memWrite)) seq_bad++;
        if (f) begin
          i = k - 1;
          wa = d + i[ADDR_W-1:0];
          if (!memWrite || memRead || address != wa || writeData != fv) seq_bad++;
          mdl[wa] = fv;
        end else if (k % 2 == 1) begin
          i = (k - 1) / 2;
          ra = s + i[ADDR_W-1:0];
          if (!memRead || memWrite || address != ra) seq_bad++;
        end else begin
          i = k / 2 - 1;
          ra = s + i[ADDR_W-1:0];
          wa = d + i[ADDR_W-1:0];
          exp_wd = mdl[ra];
          if (!memWrite || memRead || address != wa || writeData != exp_wd) seq_bad++;
          mdl[wa] = exp_wd;
        end
      end
      if (k == pulse_at) begin
        start = 1'b1; srcAddr = s + 5'd3; dstAddr = d + 5'd9; len = 6'd1;
      end else begin
        start = 1'b0;
      end
      if (done) break;
    end
    check({name, " latency"}, lat, exp_lat);
    check({name, " cycle pattern errors"}, seq_bad, 0);
    @(negedge clk);
    start = 1'b0;
`ifdef MEM_COPY_FILL_EN
    fill = 1'b0;
`endif
    check({name, " idle after done"},
          {dbg_state, busy, done, memRead, memWrite, address, writeData}, 0);
    check_mem({name, " memory contents"});
  endtask

  initial begin
    int done_seen;
    logic [DATA_W-1:0] v;

    vecs[0] = '{s: 5'd27, d: 5'd5,  n: 6'd2,  lat: 5,  pulse_at: 0};
    vecs[1] = '{s: 5'd9,  d: 5'd14, n: 6'd0,  lat: 1,  pulse_at: 0};
    vecs[2] = '{s: 5'd30, d: 5'd31, n: 6'd3,  lat: 7,  pulse_at: 0};
    vecs[3] = '{s: 5'd3,  d: 5'd4,  n: 6'd5,  lat: 11, pulse_at: 0};
    vecs[4] = '{s: 5'd0,  d: 5'd16, n: 6'd32, lat: 65, pulse_at: 0};
    vecs[5] = '{s: 5'd8,  d: 5'd20, n: 6'd3,  lat: 7,  pulse_at: 2};
    vecs[6] = '{s: 5'd1,  d: 5'd2,  n: 6'd1,  lat: 3,  pulse_at: 3};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset outputs",
          {dbg_state, busy, done, memRead, memWrite, address, writeData}, 0);
    for (int j = 0; j < 32; j++) begin
      v = DATA_W'($urandom_range(0, 255));
      poke(j[ADDR_W-1:0], v);
    end
    @(negedge clk);
    rst = 1'b1;

    for (int t = 0; t < 7; t++) begin
      if (t == 0) begin
        poke(5'd27, 8'h66);
        poke(5'd28, 8'hAA);
      end
      if (t == 2) begin
        poke(5'd30, 8'h10);
        poke(5'd31, 8'h20);
        poke(5'd0, 8'h33);
      end
      run_copy($sformatf("vec%0d", t), vecs[t].s, vecs[t].d, vecs[t].n,
               1'b0, 8'h00, vecs[t].lat, vecs[t].pulse_at);
      if (t == 0) begin
        check("vec0 mem[5]", mem[5], 8'h66);
        check("vec0 mem[6]", mem[6], 8'hAA);
      end
      if (t == 2) begin
        check("vec2 mem[31]", mem[31], 8'h10);
        check("vec2 mem[0]", mem[0], 8'h10);
        check("vec2 mem[1]", mem[1], 8'h10);
      end
    end

    // Reset during the WRITE of byte 2 of 4: only byte 1 lands, no done.
    @(negedge clk);
    srcAddr = 5'd12; dstAddr = 5'd24; len = 6'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("rst test in write of byte 2", {dbg_state, memWrite, address}, {2'd2, 1'b1, 5'd25});
    mdl[24] = mdl[12];
    rst = 1'b0;
    @(negedge clk);
    check("rst test outputs cleared",
          {dbg_state, busy, done, memRead, memWrite, address, writeData}, 0);
    rst = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check("rst test no done/busy after reset", done_seen, 0);
    check_mem("rst test memory contents");

`ifdef MEM_COPY_FILL_EN
    run_copy("fill", 5'd0, 5'd10, 6'd4, 1'b1, 8'h5A, 5, 0);
    check("fill mem[13]", mem[13], 8'h5A);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
